store_drain_buffer: RTL and testbench

Post-commit store buffer directly downstream of the store queue. Each cycle it accepts up to N retired stores from the SQ head and reports how many it took, so the SQ can release those entries. It drains the buffered stores in order to the data-memory write port, with one write outstanding at a time. It also provides a combinational forwarding probe so loads observe committed-but-undrained stores.

---
 rtl/store_drain_buffer_if.sv | 76 +++++++
 rtl/store_drain_buffer.sv | 184 ++++++++++++++++++
 tb/tb_store_drain_buffer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_drain_buffer_if.sv
// Handshake bundle between the store queue, the drain buffer,
// the data-memory write port and the load forwarding probe.
interface store_drain_buffer_if #(
    parameter int N        = 3,
    parameter int SB_DEPTH = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    localparam int MW = DATA_W / 8;
    localparam int FW = $clog2(N + 1);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic [N-1:0]        commit_valid;
    logic [N*ADDR_W-1:0] commit_addr;
    logic [N*DATA_W-1:0] commit_data;
    logic [N*MW-1:0]     commit_mask;
    logic [FW-1:0]       sq_free_count;

    logic [CW-1:0]       buf_free_slots;
    logic                buf_empty;
    logic                overflow_err;

    logic                mem_req_valid;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_data;
    logic [MW-1:0]       mem_req_mask;
    logic                mem_req_ready;
    logic                mem_resp_valid;

    logic [ADDR_W-1:0]   lookup_addr;
    logic                lookup_hit;
    logic [DATA_W-1:0]   lookup_data;
    logic [MW-1:0]       lookup_mask;

    modport master (
        output commit_valid,
        output commit_addr,
        output commit_data,
        output commit_mask,
        output mem_req_ready,
        output mem_resp_valid,
        output lookup_addr,
        input  sq_free_count,
        input  buf_free_slots,
        input  buf_empty,
        input  overflow_err,
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_data,
        input  mem_req_mask,
        input  lookup_hit,
        input  lookup_data,
        input  lookup_mask
    );

    modport slave (
        input  commit_valid,
        input  commit_addr,
        input  commit_data,
        input  commit_mask,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  lookup_addr,
        output sq_free_count,
        output buf_free_slots,
        output buf_empty,
        output overflow_err,
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_data,
        output mem_req_mask,
        output lookup_hit,
        output lookup_data,
        output lookup_mask
    );
endinterface

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: packs retired stores from the SQ head,
// drains them in order to memory and forwards them to loads.
module store_drain_buffer #(
    parameter int N        = 3,
    parameter int SB_DEPTH = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input logic                 clock,
    input logic                 reset,
    store_drain_buffer_if.slave bus
);
    localparam int MW = DATA_W / 8;
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [SB_DEPTH-1:0] vld_q;

    logic [ADDR_W-1:0] addr_q [SB_DEPTH];
    logic [DATA_W-1:0] data_q [SB_DEPTH];
    logic [MW-1:0]     mask_q [SB_DEPTH];

    logic [CW-1:0] free_slots;
    logic [CW-1:0] acc;
    logic [N-1:0]  take;
    logic [PW-1:0] slot [N];
    logic          drop;
    logic          pop;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [MW-1:0]     fwd_mask;
    logic [PW-1:0]     fidx;
    logic              unused_lkup;

    assign unused_lkup = ^bus.lookup_addr[1:0];

    // Lane packing: each accepted lane lands at tail plus the
    // number of older lanes accepted before it; reset blocks intake.
    always_comb begin
        free_slots = CW'(SB_DEPTH) - count_q;
        acc        = '0;
        take       = '0;
        drop       = 1'b0;
        for (int i = 0; i < N; i++) begin
            slot[i] = tail_q + PW'(acc);
            if (bus.commit_valid[i] && reset) begin
                if (acc < free_slots) begin
                    take[i] = 1'b1;
                    acc     = acc + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign pop = (state_q == WAIT_ACK) && bus.mem_resp_valid;

    always_comb begin
        count_d = count_q + acc - CW'(pop);
        tail_d  = tail_q + PW'(acc);
        head_d  = head_q + PW'(pop);
        ovf_d   = ovf_q | drop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (take[i]) begin
                    vld_q[slot[i]] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (take[i]) begin
                addr_q[slot[i]] <= bus.commit_addr[i*ADDR_W +: ADDR_W];
                data_q[slot[i]] <= bus.commit_data[i*DATA_W +: DATA_W];
                mask_q[slot[i]] <= bus.commit_mask[i*MW +: MW];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (pop) begin
                    state_d = (count_q > CW'(1)) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req_valid = (state_q == REQ);
        bus.mem_req_addr  = addr_q[head_q];
        bus.mem_req_data  = data_q[head_q];
        bus.mem_req_mask  = mask_q[head_q];
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_mask = '0;
        fidx     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fidx = head_q + PW'(k);
            if (vld_q[fidx] &&
                addr_q[fidx][ADDR_W-1:2] ==
                bus.lookup_addr[ADDR_W-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fidx];
                fwd_mask = mask_q[fidx];
            end
        end
    end

    always_comb begin
        bus.sq_free_count  = FW'(acc);
        bus.buf_free_slots = free_slots;
        bus.buf_empty      = (count_q == '0);
        bus.overflow_err   = ovf_q;
        bus.lookup_hit     = fwd_hit;
        bus.lookup_data    = fwd_data;
        bus.lookup_mask    = fwd_mask;
    end
endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: vector table, scoreboard
// of expected memory writes, and hand sequences for reset/ack corners.
module tb_store_drain_buffer;
    localparam int N  = 3;
    localparam int D  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_drain_buffer_if #(
        .N(N), .SB_DEPTH(D), .ADDR_W(AW), .DATA_W(DW)
    ) mif ();

    store_drain_buffer #(
        .N(N), .SB_DEPTH(D), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(mif)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } st_t;

    st_t sb[$];
    int  m_count = 0;
    int  m_state = 0;
    bit  m_ovf = 1'b0;
    int  m_enq = 0;

    // Reference model: IDLE=0 REQ=1 WAIT_ACK=2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 0;
            m_state <= 0;
            m_ovf   <= 1'b0;
            sb.delete();
        end else begin
            int acc;
            int pop;
            int ns;
            bit ov;
            acc = 0;
            pop = 0;
            ns  = m_state;
            ov  = m_ovf;
            case (m_state)
                0: if (m_count > 0) ns = 1;
                1: if (mif.mem_req_ready) begin
                    ns = 2;
                    if (sb.size() > 0) void'(sb.pop_front());
                end
                2: if (mif.mem_resp_valid) begin
                    pop = 1;
                    ns  = (m_count > 1) ? 1 : 0;
                end
                default: ns = 0;
            endcase
            for (int i = 0; i < N; i++) begin
                if (mif.commit_valid[i]) begin
                    if (acc < D - m_count) begin
                        sb.push_back(st_t'{mif.commit_addr[i*AW +: AW],
                                           mif.commit_data[i*DW +: DW],
                                           mif.commit_mask[i*MW +: MW]});
                        acc++;
                    end else begin
                        ov = 1'b1;
                    end
                end
            end
            m_count <= m_count + acc - pop;
            m_state <= ns;
            m_ovf   <= ov;
            m_enq   <= m_enq + acc;
        end
    end

    // Memory responder: manual values or random ready/ack latency.
    bit   auto_mode = 1'b0;
    logic man_ready = 1'b0;
    logic man_ack = 1'b0;

    initial begin
        bit pend;
        int pcnt;
        pend = 1'b0;
        pcnt = 0;
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                pend = 1'b0;
                mif.mem_req_ready  = 1'b0;
                mif.mem_resp_valid = 1'b0;
            end else if (!auto_mode) begin
                pend = 1'b0;
                mif.mem_req_ready  = man_ready;
                mif.mem_resp_valid = man_ack;
            end else begin
                if (pend) begin
                    if (pcnt == 0) begin
                        mif.mem_resp_valid = 1'b1;
                        pend = 1'b0;
                    end else begin
                        pcnt--;
                        mif.mem_resp_valid = 1'b0;
                    end
                end else begin
                    mif.mem_resp_valid = ($urandom_range(0, 7) == 0);
                end
                mif.mem_req_ready = 1'($urandom_range(0, 1));
                if (mif.mem_req_valid && mif.mem_req_ready) begin
                    pend = 1'b1;
                    pcnt = $urandom_range(0, 2);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: condition not reached", nm);
    endtask

    task automatic check_cycle();
        int exp_acc;
        if (!rst_n) return;
        exp_acc = $countones(mif.commit_valid);
        if (exp_acc > D - m_count) exp_acc = D - m_count;
        chk("sq_free_count", mif.sq_free_count, exp_acc);
        chk("buf_free_slots", mif.buf_free_slots, D - m_count);
        chk("buf_empty", mif.buf_empty, m_count == 0);
        chk("mem_req_valid", mif.mem_req_valid, m_state == 1);
        chk("overflow_err", mif.overflow_err, m_ovf);
        if (m_state == 1) begin
            if (sb.size() == 0) begin
                fail("scoreboard_nonempty");
            end else begin
                chk("req_addr", mif.mem_req_addr, sb[0].a);
                chk("req_data", mif.mem_req_data, sb[0].d);
                chk("req_mask", mif.mem_req_mask, sb[0].m);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] m);
        mif.commit_valid[i]          = v;
        mif.commit_addr[i*AW +: AW]  = a;
        mif.commit_data[i*DW +: DW]  = d;
        mif.commit_mask[i*MW +: MW]  = m;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (m_count == 0 && m_state == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) fail(nm);
    endtask

    typedef struct {
        logic [2:0]    v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        int            acc;
        int            free_after;
        bit            ovf_after;
    } vec_t;

    vec_t tv[6];

    initial begin
        bit got;
        int seq;
        int base;
        tv[0] = '{3'b101, 32'h1000, 32'hABCD_0000, 4'hF, 2, 6, 1'b0};
        tv[1] = '{3'b111, 32'h1100, 32'h0000_0100, 4'h3, 3, 3, 1'b0};
        tv[2] = '{3'b110, 32'h1200, 32'h0000_0200, 4'hC, 2, 1, 1'b0};
        tv[3] = '{3'b111, 32'h1300, 32'h0000_0300, 4'hF, 1, 0, 1'b1};
        tv[4] = '{3'b001, 32'h1400, 32'h0000_0400, 4'h1, 0, 0, 1'b1};
        tv[5] = '{3'b000, 32'h1500, 32'h0000_0500, 4'h2, 0, 0, 1'b1};

        mif.commit_valid = '0;
        mif.commit_addr  = '0;
        mif.commit_data  = '0;
        mif.commit_mask  = '0;
        mif.lookup_addr  = '0;

        // Reset state, with lanes offered while reset is held
        mif.commit_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free_slots", mif.buf_free_slots, 8);
        chk("rst_empty", mif.buf_empty, 1);
        chk("rst_req_valid", mif.mem_req_valid, 0);
        chk("rst_ovf", mif.overflow_err, 0);
        chk("rst_hit", mif.lookup_hit, 0);
        chk("rst_sq_free", mif.sq_free_count, 0);
        mif.commit_valid = '0;
        rst_n = 1'b1;
        step();

        // Vector table: fill without draining, then overflow
        man_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                set_lane(i, tv[k].v[i], tv[k].a + 32'(4 * i),
                         tv[k].d + 32'(i), tv[k].m);
            end
            @(negedge clk);
            check_cycle();
            chk($sformatf("tv%0d_sq_free", k), mif.sq_free_count, tv[k].acc);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_free", k), mif.buf_free_slots,
                tv[k].free_after);
            chk($sformatf("tv%0d_ovf", k), mif.overflow_err, tv[k].ovf_after);
        end
        mif.commit_valid = '0;
        chk("t2_req_valid", mif.mem_req_valid, 1);
        chk("t2_req_addr", mif.mem_req_addr, 32'h1000);

        // Ready held low: request fields must stay stable
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_cycle();
            chk("t3_hold_valid", mif.mem_req_valid, 1);
            chk("t3_hold_addr", mif.mem_req_addr, 32'h1000);
            chk("t3_hold_data", mif.mem_req_data, 32'hABCD_0000);
            @(posedge clk);
            #1;
        end
        man_ready = 1'b1;
        step();
        man_ready = 1'b0;
        chk("t3_wait_valid", mif.mem_req_valid, 0);
        step();
        man_ack = 1'b1;
        @(negedge clk);
        check_cycle();
        chk("t3_ack_cycle_free", mif.buf_free_slots, 0);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        chk("t3_pop_free", mif.buf_free_slots, 1);
        chk("t3_next_valid", mif.mem_req_valid, 1);
        chk("t3_next_addr", mif.mem_req_addr, 32'h1008);
        chk("t3_ovf_sticky", mif.overflow_err, 1);

        auto_mode = 1'b1;
        drain("t3_drain_timeout");
        chk("t3_drained_empty", mif.buf_empty, 1);

        // Forwarding: youngest match wins, same-cycle enqueue invisible
        auto_mode = 1'b0;
        man_ready = 1'b0;
        step();
        mif.lookup_addr = 32'h2002;
        set_lane(0, 1'b1, 32'h2000, 32'h11, 4'hF);
        @(negedge clk);
        check_cycle();
        chk("t5_not_yet_hit", mif.lookup_hit, 0);
        @(posedge clk);
        #1;
        set_lane(0, 1'b1, 32'h2000, 32'h22, 4'h3);
        @(negedge clk);
        check_cycle();
        chk("t5_old_hit", mif.lookup_hit, 1);
        chk("t5_old_data", mif.lookup_data, 32'h11);
        chk("t5_old_mask", mif.lookup_mask, 4'hF);
        @(posedge clk);
        #1;
        mif.commit_valid = '0;
        @(negedge clk);
        check_cycle();
        chk("t5_young_hit", mif.lookup_hit, 1);
        chk("t5_young_data", mif.lookup_data, 32'h22);
        chk("t5_young_mask", mif.lookup_mask, 4'h3);
        mif.lookup_addr = 32'h2004;
        #1;
        chk("t5_miss_hit", mif.lookup_hit, 0);
        chk("t5_miss_data", mif.lookup_data, 0);
        chk("t5_miss_mask", mif.lookup_mask, 0);
        mif.lookup_addr = 32'h1008;
        #1;
        chk("t5_drained_miss", mif.lookup_hit, 0);
        mif.lookup_addr = 32'h2000;
        @(posedge clk);
        #1;
        auto_mode = 1'b1;
        drain("t5_drain_timeout");
        chk("t5_after_hit", mif.lookup_hit, 0);
        chk("t5_after_data", mif.lookup_data, 0);

        // Random traffic across wrap, reset during WAIT_ACK
        base = m_enq;
        seq  = 0;
        for (int c = 0; c < 400 && m_enq - base < 20; c++) begin
            for (int i = 0; i < N; i++) begin
                set_lane(i, 1'($urandom_range(0, 1)),
                         32'h5000 + 32'(4 * (seq + i)),
                         32'h6000_0000 + 32'(seq + i),
                         4'($urandom_range(1, 15)));
            end
            seq += N;
            step();
        end
        mif.commit_valid = '0;
        if (m_enq - base < 20) fail("t6_push_timeout");
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (m_state == 2) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) fail("t6_no_wait_ack");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_empty", mif.buf_empty, 1);
        chk("t6_rst_req_valid", mif.mem_req_valid, 0);
        chk("t6_rst_free", mif.buf_free_slots, 8);
        chk("t6_rst_ovf", mif.overflow_err, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();
        chk("t6_post_empty", mif.buf_empty, 1);

        // Ack arriving after a reset that abandoned a write
        auto_mode = 1'b0;
        man_ready = 1'b0;
        man_ack   = 1'b0;
        step();
        set_lane(0, 1'b1, 32'h7000, 32'h77, 4'hF);
        step();
        mif.commit_valid = '0;
        step();
        man_ready = 1'b1;
        step();
        man_ready = 1'b0;
        chk("t7_in_wait", mif.mem_req_valid, 0);
        chk("t7_pending", mif.buf_free_slots, 7);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_free", mif.buf_free_slots, 8);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        step();
        chk("t7_free", mif.buf_free_slots, 8);
        chk("t7_empty", mif.buf_empty, 1);
        chk("t7_req_valid", mif.mem_req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
